// File: rtl/div_pkg.sv
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential signed divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int c_width_default = 8;
    localparam int c_cnt_width     = $clog2(c_width_default);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
//  Module      : div_step
//  Description : One restoring shift-subtract iteration (combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_p,
    input  logic             i_din,
    input  logic [WIDTH-1:0] i_bmag,
    output logic [WIDTH:0]   o_p_next,
    output logic             o_qbit
);

    // One guard bit above the partial remainder keeps the trial sign exact.
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;

    always_comb begin
        w_shift  = {i_p, i_din};
        w_trial  = w_shift - {2'b00, i_bmag};
        o_qbit   = ~w_trial[WIDTH+1];
        o_p_next = o_qbit ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
    end

endmodule : div_step

`default_nettype wire

// File: rtl/seq_signed_divider.sv
// ============================================================================
//  Module      : seq_signed_divider
//  Description : Multi-cycle signed divider, truncating quotient/remainder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int c_cnt_w = $clog2(WIDTH);

    div_state_t       r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_bmag;
    logic [WIDTH-1:0] r_a;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dz;
    logic             r_ov;

    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic             w_b_zero;
    logic             w_ov;
    logic [WIDTH:0]   w_p_next;
    logic             w_qbit;

    always_comb begin
        w_amag   = a[WIDTH-1] ? -a : a;
        w_bmag   = b[WIDTH-1] ? -b : b;
        w_b_zero = (b == '0);
        w_ov     = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_p      (r_p),
        .i_din    (r_dvd[WIDTH-1]),
        .i_bmag   (r_bmag),
        .o_p_next (w_p_next),
        .o_qbit   (w_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_p         <= '0;
            r_dvd       <= '0;
            r_bmag      <= '0;
            r_a         <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dz        <= 1'b0;
            r_ov        <= 1'b0;
            q           <= '0;
            r           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_sign_r <= a[WIDTH-1];
                        r_dvd    <= w_amag;
                        r_bmag   <= w_bmag;
                        r_a      <= a;
                        r_p      <= '0;
                        r_cnt    <= '0;
                        r_dz     <= w_b_zero;
                        r_ov     <= w_ov;
                        busy     <= 1'b1;
                        // Zero divisor skips iteration; FIX writes its fixed result.
                        r_state  <= w_b_zero ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_p   <= w_p_next;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_dz) begin
                        q <= '1;
                        r <= r_a;
                    end else begin
                        q <= r_sign_q ? -r_dvd : r_dvd;
                        r <= r_sign_r ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
                    end
                    div_by_zero <= r_dz;
                    overflow    <= r_ov;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : seq_signed_divider

`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
// ============================================================================
//  Module      : tb_seq_signed_divider
//  Description : Self-checking bench for seq_signed_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_signed_divider;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         lat;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       overflow;

    int checks;
    int errors;

    seq_signed_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .q           (q),
        .r           (r),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: C-style truncating division with the divider's special cases.
    function automatic vec_t model(input logic [7:0] ma, input logic [7:0] mb);
        vec_t v;
        int ia;
        int ib;
        ia   = int'($signed(ma));
        ib   = int'($signed(mb));
        v.a  = ma;
        v.b  = mb;
        v.dz = 1'b0;
        v.ov = 1'b0;
        v.lat = 10;
        if (ib == 0) begin
            v.q = 8'hFF;
            v.r = ma;
            v.dz = 1'b1;
            v.lat = 2;
        end else if (ia == -128 && ib == -1) begin
            v.q = 8'h80;
            v.r = 8'h00;
            v.ov = 1'b1;
        end else begin
            v.q = 8'(ia / ib);
            v.r = 8'(ia % ib);
        end
        return v;
    endfunction

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 30) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_in,
                          output int lat, output int bcnt);
        @(negedge clk);
        a     = ta;
        b     = tb_in;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
    endtask

    task automatic check_result(input string name, input vec_t e);
        chk({name, "_q"}, int'(q), int'(e.q));
        chk({name, "_r"}, int'(r), int'(e.r));
        chk({name, "_dz"}, int'(div_by_zero), int'(e.dz));
        chk({name, "_ov"}, int'(overflow), int'(e.ov));
    endtask

    vec_t tbl[8];
    vec_t exp_q[$];

    initial begin
        int lat;
        int bcnt;
        int ndone;
        int cyc;
        int since;
        int extra;
        vec_t e;
        vec_t cur;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        tbl[0] = '{8'd100,  8'd7,    8'd14,   8'd2,   1'b0, 1'b0, 10};
        tbl[1] = '{8'h9C,   8'd7,    8'hF2,   8'hFE,  1'b0, 1'b0, 10};
        tbl[2] = '{8'd100,  8'hF9,   8'hF2,   8'd2,   1'b0, 1'b0, 10};
        tbl[3] = '{8'h9C,   8'hF9,   8'd14,   8'hFE,  1'b0, 1'b0, 10};
        tbl[4] = '{8'd5,    8'd0,    8'hFF,   8'd5,   1'b1, 1'b0, 2};
        tbl[5] = '{8'd9,    8'd3,    8'd3,    8'd0,   1'b0, 1'b0, 10};
        tbl[6] = '{8'h80,   8'hFF,   8'h80,   8'd0,   1'b0, 1'b1, 10};
        tbl[7] = '{8'h80,   8'd1,    8'h80,   8'd0,   1'b0, 1'b0, 10};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_q", int'(q), 0);
        chk("reset_r", int'(r), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_flags", int'({div_by_zero, overflow}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, lat, bcnt);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, tbl[i].lat);
            chk($sformatf("vec%0d_busy_at_done", i), int'(busy), 0);
            check_result($sformatf("vec%0d", i), tbl[i]);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_single", i), int'(done), 0);
        end

        // start mid-CALC must be ignored
        @(negedge clk);
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 8'd50; b = 8'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("midcalc_latency", lat + 4, 10);
        check_result("midcalc", tbl[0]);
        extra = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        chk("midcalc_no_queued_op", extra, 0);

        // asynchronous reset mid-CALC
        @(negedge clk);
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_q", int'(q), 0);
        chk("async_rst_r", int'(r), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd20, 8'd6, lat, bcnt);
        chk("after_rst_latency", lat, 10);
        check_result("after_rst", model(8'd20, 8'd6));

        // randomized back-to-back run with start held high
        @(negedge clk);
        cur = model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        exp_q.push_back(cur);
        a = cur.a; b = cur.b; start = 1'b1;
        ndone = 0;
        cyc   = 0;
        since = 0;
        while (ndone < 500 && cyc < 10000) begin
            @(posedge clk);
            #1;
            cyc++;
            since++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_result($sformatf("rand%0d", ndone), e);
                    chk($sformatf("rand%0d_interval", ndone), since, e.lat + 1);
                end
                ndone++;
                since = 0;
                if (ndone < 500) begin
                    case ($urandom_range(0, 19))
                        0: cur = model(8'($urandom_range(0, 255)), 8'd0);
                        1: cur = model(8'h80, 8'hFF);
                        default: cur = model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                    endcase
                    exp_q.push_back(cur);
                    a = cur.a;
                    b = cur.b;
                end
            end
        end
        start = 1'b0;
        chk("rand_done_count", ndone, 500);
        extra = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        chk("rand_no_extra_done", extra, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_signed_divider

`default_nettype wire
